// File: rtl/chacha_arbiter.sv
// chacha_arbiter: shares one ChaCha core between two requesters (ch0 = TX manager,
// ch1 = RX/aux manager). Round-robin grant, run-to-completion jobs, operand latching,
// core start/valid sequencing and a per-channel valid/ready response path.
// Optional watchdog on the core result enabled by defining ARB_TIMEOUT_EN.
module chacha_arbiter #(
  parameter int unsigned KEY_WIDTH         = 256,
  parameter int unsigned NONCE_WIDTH       = 96,
  parameter int unsigned BLOCK_COUNT_WIDTH = 32,
  parameter int unsigned DATA_WIDTH        = 512,
  parameter int unsigned TIMEOUT_CYCLES    = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [1:0]                     req_valid,
  output logic [1:0]                     req_ready,
  input  logic [2*KEY_WIDTH-1:0]         req_key,
  input  logic [2*NONCE_WIDTH-1:0]       req_nonce,
  input  logic [2*BLOCK_COUNT_WIDTH-1:0] req_block_count,
  input  logic [2*DATA_WIDTH-1:0]        req_data,
  output logic [1:0]                     rsp_valid,
  input  logic [1:0]                     rsp_ready,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic [KEY_WIDTH-1:0]           core_key,
  output logic [NONCE_WIDTH-1:0]         core_nonce,
  output logic [BLOCK_COUNT_WIDTH-1:0]   core_block_count,
  output logic [DATA_WIDTH-1:0]          core_data,
  output logic                           core_start,
  input  logic                           core_ready,
  input  logic                           core_valid,
  input  logic [DATA_WIDTH-1:0]          core_data_out,
  output logic                           busy,
`ifdef ARB_TIMEOUT_EN
  output logic                           timeout_err,
`endif
  output logic                           owner
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                         r_state;
  state_e                         w_state_d;
  logic                           r_last_grant;
  logic                           r_owner;
  logic [KEY_WIDTH-1:0]           r_core_key;
  logic [NONCE_WIDTH-1:0]         r_core_nonce;
  logic [BLOCK_COUNT_WIDTH-1:0]   r_core_block_count;
  logic [DATA_WIDTH-1:0]          r_core_data;
  logic [DATA_WIDTH-1:0]          r_rsp_data;

  logic                           w_grant;
  logic                           w_accept;
  logic                           w_capture;
  logic                           w_release;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0]                r_wait_cnt;
  logic                           r_timeout_err;
  logic                           w_timeout;
`endif

  // Round-robin pick: a lone requester wins, a tie goes to the channel not served last.
  always_comb begin
    w_grant = 1'b0;
    case (req_valid)
      2'b01:   w_grant = 1'b0;
      2'b10:   w_grant = 1'b1;
      2'b11:   w_grant = ~r_last_grant;
      default: w_grant = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    w_state_d  = r_state;
    req_ready  = 2'b00;
    rsp_valid  = 2'b00;
    core_start = 1'b0;
    w_accept   = 1'b0;
    w_capture  = 1'b0;
    w_release  = 1'b0;
`ifdef ARB_TIMEOUT_EN
    w_timeout  = 1'b0;
`endif
    case (r_state)
      StIdle: begin
        // Ready only toward a valid requester, so ready implies handshake.
        if (|req_valid) begin
          req_ready[w_grant] = 1'b1;
          w_accept           = 1'b1;
          w_state_d          = StIssue;
        end
      end
      StIssue: begin
        core_start = core_ready;
        if (core_ready) begin
          w_state_d = StWait;
        end
      end
      StWait: begin
        if (core_valid) begin
          w_capture = 1'b1;
          w_state_d = StResp;
        end
`ifdef ARB_TIMEOUT_EN
        else if (r_wait_cnt == CntW'(TIMEOUT_CYCLES - 1)) begin
          w_timeout = 1'b1;
          w_state_d = StResp;
        end
`endif
      end
      StResp: begin
        rsp_valid[r_owner] = 1'b1;
        if (rsp_ready[r_owner]) begin
          w_release = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Operand latch, result capture and round-robin history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant       <= 1'b1;
      r_owner            <= 1'b0;
      r_core_key         <= '0;
      r_core_nonce       <= '0;
      r_core_block_count <= '0;
      r_core_data        <= '0;
      r_rsp_data         <= '0;
    end else begin
      if (w_accept) begin
        r_owner            <= w_grant;
        r_core_key         <= w_grant ? req_key[KEY_WIDTH +: KEY_WIDTH]
                                      : req_key[0 +: KEY_WIDTH];
        r_core_nonce       <= w_grant ? req_nonce[NONCE_WIDTH +: NONCE_WIDTH]
                                      : req_nonce[0 +: NONCE_WIDTH];
        r_core_block_count <= w_grant ? req_block_count[BLOCK_COUNT_WIDTH +: BLOCK_COUNT_WIDTH]
                                      : req_block_count[0 +: BLOCK_COUNT_WIDTH];
        r_core_data        <= w_grant ? req_data[DATA_WIDTH +: DATA_WIDTH]
                                      : req_data[0 +: DATA_WIDTH];
      end
      if (w_capture) begin
        r_rsp_data <= core_data_out;
      end
`ifdef ARB_TIMEOUT_EN
      if (w_timeout) begin
        r_rsp_data <= '0;
      end
`endif
      if (w_release) begin
        r_last_grant <= r_owner;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Watchdog: counts WAIT cycles from zero; error flag is sticky until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == StIssue && core_ready) begin
        r_wait_cnt <= '0;
      end else if (r_state == StWait) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`endif

  assign busy             = (r_state != StIdle);
  assign owner            = r_owner;
  assign rsp_data         = r_rsp_data;
  assign core_key         = r_core_key;
  assign core_nonce       = r_core_nonce;
  assign core_block_count = r_core_block_count;
  assign core_data        = r_core_data;

endmodule

// File: tb/tb_chacha_arbiter.sv
// Self-checking bench for chacha_arbiter. The bench plays both requesters and the core;
// a small model tracks which channel was served last and what each job should produce.
module tb_chacha_arbiter;

  localparam int KW = 256;
  localparam int NW = 96;
  localparam int BW = 32;
  localparam int DW = 512;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_ready;
  logic [2*KW-1:0] req_key = '0;
  logic [2*NW-1:0] req_nonce = '0;
  logic [2*BW-1:0] req_block_count = '0;
  logic [2*DW-1:0] req_data = '0;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready = '0;
  logic [DW-1:0]   rsp_data;
  logic [KW-1:0]   core_key;
  logic [NW-1:0]   core_nonce;
  logic [BW-1:0]   core_block_count;
  logic [DW-1:0]   core_data;
  logic            core_start;
  logic            core_ready = 1'b0;
  logic            core_valid = 1'b0;
  logic [DW-1:0]   core_data_out = '0;
  logic            busy;
  logic            owner;
`ifdef ARB_TIMEOUT_EN
  logic            timeout_err;
`endif

  int total = 0;
  int bad = 0;
  // Model: channel served most recently (reset makes ch0 win the first tie).
  int m_last = 1;

  always #5 clk = ~clk;

  chacha_arbiter #(
    .KEY_WIDTH        (KW),
    .NONCE_WIDTH      (NW),
    .BLOCK_COUNT_WIDTH(BW),
    .DATA_WIDTH       (DW),
    .TIMEOUT_CYCLES   (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_key         (req_key),
    .req_nonce       (req_nonce),
    .req_block_count (req_block_count),
    .req_data        (req_data),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .core_key        (core_key),
    .core_nonce      (core_nonce),
    .core_block_count(core_block_count),
    .core_data       (core_data),
    .core_start      (core_start),
    .core_ready      (core_ready),
    .core_valid      (core_valid),
    .core_data_out   (core_data_out),
    .busy            (busy),
`ifdef ARB_TIMEOUT_EN
    .timeout_err     (timeout_err),
`endif
    .owner           (owner)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_bits();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic apply_reset();
    cyc();
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    core_ready = 1'b0;
    core_valid = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    m_last = 1;
  endtask

  // One complete job: request, ISSUE (core_ready low rdel cycles), WAIT (vdel quiet
  // cycles then result), RESP (owner's rsp_ready low pdel cycles).
  task automatic do_job(input logic [1:0] mask, input int rdel, input int vdel,
                        input int pdel, input bit fixed);
    logic [KW-1:0] k[2];
    logic [NW-1:0] n[2];
    logic [BW-1:0] b[2];
    logic [DW-1:0] d[2];
    logic [DW-1:0] res;
    logic [DW-1:0] tmp;
    logic [1:0]    gbit;
    int            g;
    for (int c = 0; c < 2; c++) begin
      tmp = rnd_bits();
      k[c] = tmp[KW-1:0];
      n[c] = tmp[KW +: NW];
      b[c] = tmp[KW+NW +: BW];
      d[c] = rnd_bits();
    end
    res = rnd_bits();
    if (fixed) begin
      k[0] = '1;
      d[0] = {16{32'h12345678}};
      res  = {16{32'hABCD0123}};
    end
    g    = (mask == 2'b01) ? 0 : (mask == 2'b10) ? 1 : 1 - m_last;
    gbit = (g == 0) ? 2'b01 : 2'b10;

    cyc();
    req_key = {k[1], k[0]};
    req_nonce = {n[1], n[0]};
    req_block_count = {b[1], b[0]};
    req_data = {d[1], d[0]};
    req_valid = mask;
    core_ready = 1'b0;
    core_valid = 1'b0;
    rsp_ready = 2'b00;
    @(negedge clk);
    total++;
    if (req_ready !== gbit) begin
      bad++;
      $display("FAIL grant: req_ready=%b want %b (mask %b)", req_ready, gbit, mask);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_busy: busy=%b want 0", busy);
    end

    for (int i = 0; i <= rdel; i++) begin
      cyc();
      if (i == 0) begin
        // Granted channel moves on; its new operands must not leak into the core.
        req_valid = mask & ~gbit;
        tmp = rnd_bits();
        req_key[g*KW +: KW] = tmp[KW-1:0];
        req_data[g*DW +: DW] = rnd_bits();
      end
      core_ready = (i == rdel);
      @(negedge clk);
      total++;
      if (core_start !== (i == rdel)) begin
        bad++;
        $display("FAIL issue_start: cycle %0d core_start=%b want %b", i, core_start, i == rdel);
      end
      total++;
      if (core_key !== k[g] || core_data !== d[g]) begin
        bad++;
        $display("FAIL operands_kd: key=%h want %h", core_key, k[g]);
      end
      total++;
      if ({core_nonce, core_block_count} !== {n[g], b[g]}) begin
        bad++;
        $display("FAIL operands_nb: got %h want %h", {core_nonce, core_block_count},
                 {n[g], b[g]});
      end
      total++;
      if (owner !== g[0] || busy !== 1'b1 || req_ready !== 2'b00) begin
        bad++;
        $display("FAIL issue_status: owner=%b busy=%b req_ready=%b want %0d 1 00", owner, busy,
                 req_ready, g);
      end
    end

    for (int i = 0; i <= vdel; i++) begin
      cyc();
      core_ready = 1'($urandom_range(0, 1));
      core_valid = (i == vdel);
      core_data_out = (i == vdel) ? res : rnd_bits();
      @(negedge clk);
      total++;
      if (rsp_valid !== 2'b00 || core_start !== 1'b0 || req_ready !== 2'b00) begin
        bad++;
        $display("FAIL wait: rsp_valid=%b core_start=%b req_ready=%b want 00 0 00", rsp_valid,
                 core_start, req_ready);
      end
    end

    for (int i = 0; i <= pdel; i++) begin
      cyc();
      core_valid = 1'($urandom_range(0, 1));
      core_data_out = rnd_bits();
      rsp_ready = (i == pdel) ? gbit : (2'b11 ^ gbit);
      @(negedge clk);
      total++;
      if (rsp_valid !== gbit) begin
        bad++;
        $display("FAIL rsp_valid: got %b want %b", rsp_valid, gbit);
      end
      total++;
      if (rsp_data !== res) begin
        bad++;
        $display("FAIL rsp_data: got %h want %h", rsp_data, res);
      end
      total++;
      if (req_ready !== 2'b00 || core_start !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL resp_status: req_ready=%b core_start=%b busy=%b want 00 0 1", req_ready,
                 core_start, busy);
      end
    end
    m_last = g;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    total++;
    if ({req_ready, rsp_valid, core_start, busy, owner} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl: %b want 0", {req_ready, rsp_valid, core_start, busy, owner});
    end
    total++;
    if (rsp_data !== '0 || core_data !== '0 || core_key !== '0) begin
      bad++;
      $display("FAIL reset_data: rsp_data=%h want 0", rsp_data);
    end
    total++;
    if (core_nonce !== '0 || core_block_count !== '0) begin
      bad++;
      $display("FAIL reset_nb: nonce=%h bc=%h want 0", core_nonce, core_block_count);
    end
    apply_reset();
    @(negedge clk);
    total++;
    if (req_ready !== 2'b00 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: req_ready=%b busy=%b want 00 0", req_ready, busy);
    end
  endtask

  task automatic test_single();
    apply_reset();
    do_job(2'b01, 0, 20, 0, 1'b1);
  endtask

  task automatic test_fairness();
    apply_reset();
    for (int j = 0; j < 4; j++) do_job(2'b11, 0, 3, 0, 1'b0);
  endtask

  task automatic test_issue_stall();
    do_job(2'b10, 5, 2, 0, 1'b0);
  endtask

  task automatic test_rsp_backpressure();
    do_job(2'b01, 1, 4, 7, 1'b0);
  endtask

  task automatic test_random();
    for (int j = 0; j < 8; j++) begin
      do_job(2'($urandom_range(1, 3)), $urandom_range(0, 4), $urandom_range(0, 6),
             $urandom_range(0, 3), 1'b0);
    end
  endtask

  task automatic test_reset_mid_job();
    apply_reset();
    cyc();
    req_data[0 +: DW] = rnd_bits();
    req_valid = 2'b01;
    cyc();
    req_valid = 2'b00;
    core_ready = 1'b1;
    cyc();
    core_ready = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_busy: busy=%b want 1", busy);
    end
    reset = 1'b1;
    #2;
    total++;
    if ({req_ready, rsp_valid, core_start, busy, owner} !== 7'b0 || core_data !== '0) begin
      bad++;
      $display("FAIL mid_reset: ctrl=%b want 0", {req_ready, rsp_valid, core_start, busy, owner});
    end
    cyc();
    reset = 1'b0;
    m_last = 1;
    cyc();
    core_valid = 1'b1;
    core_data_out = rnd_bits();
    cyc();
    core_valid = 1'b0;
    @(negedge clk);
    total++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_data !== '0) begin
      bad++;
      $display("FAIL late_valid: rsp_valid=%b busy=%b want 00 0", rsp_valid, busy);
    end
    do_job(2'b10, 0, 2, 1, 1'b0);
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    do_job(2'b01, 0, 1, 0, 1'b0);
    cyc();
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    core_valid = 1'b0;
    cyc();
    req_valid = 2'b00;
    core_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      core_ready = 1'b0;
      @(negedge clk);
      total++;
      if (rsp_valid !== 2'b00 || timeout_err !== 1'b0) begin
        bad++;
        $display("FAIL to_wait: cycle %0d rsp_valid=%b err=%b want 00 0", i, rsp_valid,
                 timeout_err);
      end
    end
    cyc();
    rsp_ready = 2'b01;
    @(negedge clk);
    total++;
    if (rsp_valid !== 2'b01 || rsp_data !== '0 || timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL to_resp: rsp_valid=%b err=%b rsp_data=%h want 01 1 0", rsp_valid,
               timeout_err, rsp_data);
    end
    m_last = 0;
    do_job(2'b10, 0, 2, 0, 1'b0);
    total++;
    if (timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL to_sticky: err=%b want 1", timeout_err);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_issue_stall();
    test_rsp_backpressure();
    test_random();
    test_reset_mid_job();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
